// File: rtl/input_sync_filter_pkg.sv
// rtl/input_sync_filter_pkg.sv - shared default widths for the input filter and validation-delay stages
package input_sync_filter_pkg;

    // Synchroniser depth; legal range is 2..4.
    localparam int unsigned SYNC_STAGES_DEF   = 2;
    // Width of the prescale value and the tick counter.
    localparam int unsigned PRESCALE_BITS_DEF = 8;
    // Width of the filter count and the mismatch counter.
    localparam int unsigned FILTER_BITS_DEF   = 4;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable sample-tick generator, usable as a clock enable
module tick_prescaler #(
    parameter int unsigned BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] period,
    output logic            tick
);

    logic [BITS-1:0] cnt;
    logic [BITS-1:0] last;

    // Terminal count is period-1, saturating so that 0 and 1 both tick every clock.
    always_comb begin
        last = '0;
        if (period != '0) begin
            last = period - BITS'(1);
        end
    end

    // Count enabled clocks; >= lets a lowered period wrap on the very next clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt >= last) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + BITS'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/input_sync_filter.sv
// rtl/input_sync_filter.sv - synchroniser, sample prescaler and N-tick glitch filter for board inputs
module input_sync_filter
    import input_sync_filter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned PRESCALE_BITS = PRESCALE_BITS_DEF,
    parameter int unsigned FILTER_BITS   = FILTER_BITS_DEF,
    parameter logic        RESET_VALUE   = 1'b0
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iEn,
    input  logic                     iRaw,
    input  logic [PRESCALE_BITS-1:0] ivPrescale,
    input  logic [FILTER_BITS-1:0]   ivFilterCnt,
    output logic                     oTick,
    output logic                     oLevel,
    output logic                     oRise,
    output logic                     oFall,
    output logic                     oGlitch
);

    localparam int unsigned MW = FILTER_BITS + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   sample_q;
    logic [FILTER_BITS-1:0] mcnt;
    logic [FILTER_BITS-1:0] neff;
    logic [MW-1:0]          mcnt_inc;
    logic                   eval;

    // Metastability chain for the asynchronous pin.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iRaw};
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

    // Capture the synchronised level on the same edge the tick is registered, so the
    // filter judges the value that belongs to that tick.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sample_q <= RESET_VALUE;
        end else begin
            sample_q <= s_sync;
        end
    end

    tick_prescaler #(
        .BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clk   (iClk),
        .rst_n (iRst_n),
        .en    (iEn),
        .period(ivPrescale),
        .tick  (oTick)
    );

    // Effective threshold (0 counts as 1), widened increment and evaluation strobe.
    always_comb begin
        neff = ivFilterCnt;
        if (ivFilterCnt == '0) begin
            neff = FILTER_BITS'(1);
        end
        mcnt_inc = {1'b0, mcnt} + MW'(1);
        eval     = oTick & iEn;
    end

    // Flip only after neff consecutive mismatching ticks; any matching tick restarts the run.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oLevel  <= RESET_VALUE;
            mcnt    <= '0;
            oRise   <= 1'b0;
            oFall   <= 1'b0;
            oGlitch <= 1'b0;
        end else begin
            oRise   <= 1'b0;
            oFall   <= 1'b0;
            oGlitch <= 1'b0;
            if (eval) begin
                if (sample_q == oLevel) begin
                    oGlitch <= (mcnt != '0);
                    mcnt    <= '0;
                end else if (mcnt_inc >= {1'b0, neff}) begin
                    oLevel <= sample_q;
                    mcnt   <= '0;
                    oRise  <= sample_q;
                    oFall  <= ~sample_q;
                end else begin
                    mcnt <= mcnt_inc[FILTER_BITS-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_input_sync_filter.sv
// tb/tb_input_sync_filter.sv - randomized and directed bench for input_sync_filter
module tb_input_sync_filter;

    localparam int SYNC = 2;
    localparam int PB   = 8;
    localparam int FB   = 4;
    localparam bit RV   = 1'b0;

    logic          iClk = 1'b0;
    logic          iRst_n = 1'b0;
    logic          iEn = 1'b0;
    logic          iRaw = 1'b0;
    logic [PB-1:0] ivPrescale = PB'(1);
    logic [FB-1:0] ivFilterCnt = FB'(3);
    logic          oTick, oLevel, oRise, oFall, oGlitch;

    int errors = 0;
    int checks = 0;

    // Reference state: a delay line of raw samples, a phase counter and a run length.
    bit m_dly[$];
    int m_phase;
    int m_run;
    bit m_tick, m_level, m_rise, m_fall, m_glitch;

    always #5 iClk = ~iClk;

    input_sync_filter #(
        .SYNC_STAGES  (SYNC),
        .PRESCALE_BITS(PB),
        .FILTER_BITS  (FB),
        .RESET_VALUE  (RV)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iEn        (iEn),
        .iRaw       (iRaw),
        .ivPrescale (ivPrescale),
        .ivFilterCnt(ivFilterCnt),
        .oTick      (oTick),
        .oLevel     (oLevel),
        .oRise      (oRise),
        .oFall      (oFall),
        .oGlitch    (oGlitch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_dly.delete();
        for (int i = 0; i < SYNC + 1; i++) m_dly.push_back(RV);
        m_phase  = 0;
        m_run    = 0;
        m_tick   = 1'b0;
        m_level  = RV;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_glitch = 1'b0;
    endfunction

    // The filter sees the raw value from SYNC+1 edges back, on ticks from the previous edge.
    function automatic void model_edge();
        bit s;
        int neff;
        int per;
        if (!iRst_n) return;
        s = m_dly.pop_front();
        m_dly.push_back(iRaw);
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_glitch = 1'b0;
        if (m_tick && iEn) begin
            neff = (ivFilterCnt == 0) ? 1 : int'(ivFilterCnt);
            if (s == m_level) begin
                m_glitch = (m_run != 0);
                m_run    = 0;
            end else if (m_run + 1 >= neff) begin
                m_level = s;
                m_rise  = s;
                m_fall  = !s;
                m_run   = 0;
            end else begin
                m_run++;
            end
        end
        per = (ivPrescale == 0) ? 1 : int'(ivPrescale);
        if (iEn) begin
            if (m_phase + 1 >= per) begin
                m_tick  = 1'b1;
                m_phase = 0;
            end else begin
                m_tick = 1'b0;
                m_phase++;
            end
        end else begin
            m_tick = 1'b0;
        end
    endfunction

    task automatic compare_all();
        check("tick", oTick, m_tick);
        check("level", oLevel, m_level);
        check("rise", oRise, m_rise);
        check("fall", oFall, m_fall);
        check("glitch", oGlitch, m_glitch);
    endtask

    task automatic step();
        @(posedge iClk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edges until oTick is seen again, -1 if it never comes.
    task automatic tick_interval(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (oTick) begin
                n = i;
                break;
            end
        end
    endtask

    // Edges until oLevel equals the wanted value, -1 if it never does.
    task automatic level_latency(input logic want, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (oLevel == want) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        int r;
        int hold;

        model_reset();
        iRst_n = 1'b0;
        steps(3);
        check("rst_level", oLevel, 0);
        check("rst_tick", oTick, 0);
        check("rst_pulses", {oRise, oFall, oGlitch}, 0);
        iRst_n = 1'b1;

        // Test 1: clean step, P=1, N=3.
        ivPrescale  = PB'(1);
        ivFilterCnt = FB'(3);
        iRaw        = 1'b0;
        iEn         = 1'b1;
        steps(5);
        iRaw = 1'b1;
        level_latency(1'b1, n);
        check("t1_latency", n, 6);
        check("t1_rise", oRise, 1);

        // Test 2: two-clock pulse is rejected with a single glitch report.
        iRaw = 1'b0;
        level_latency(1'b0, n);
        steps(4);
        iRaw = 1'b1;
        steps(2);
        iRaw = 1'b0;
        g = 0;
        r = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            g += int'(oGlitch);
            r += int'(oRise);
        end
        check("t2_glitches", g, 1);
        check("t2_rises", r, 0);
        check("t2_level", oLevel, 0);

        // Test 3: tick period 4, then lower the period mid-count.
        ivPrescale  = PB'(4);
        ivFilterCnt = FB'(2);
        steps(8);
        tick_interval(n);
        tick_interval(n);
        check("t3_period4_a", n, 4);
        tick_interval(n);
        check("t3_period4_b", n, 4);
        steps(2);
        ivPrescale = PB'(2);
        step();
        check("t3_wrap_next", oTick, 1);
        tick_interval(n);
        check("t3_period2_a", n, 2);
        tick_interval(n);
        check("t3_period2_b", n, 2);

        // Test 4: filter count 0 acts as 1.
        ivPrescale  = PB'(1);
        ivFilterCnt = FB'(0);
        iRaw        = 1'b1;
        steps(10);
        check("t4_level_high", oLevel, 1);
        iRaw = 1'b0;
        level_latency(1'b0, n);
        check("t4_fall_latency", n, 4);
        check("t4_fall", oFall, 1);

        // Test 5: reset with two of three mismatches counted.
        ivFilterCnt = FB'(3);
        steps(4);
        iRaw = 1'b1;
        steps(5);
        #1;
        iRst_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst_tick", oTick, 0);
        check("t5_rst_level", oLevel, 0);
        check("t5_rst_pulses", {oRise, oFall, oGlitch}, 0);
        step();
        iRst_n = 1'b1;
        level_latency(1'b1, n);
        check("t5_full_window", n, 6);

        // Test 6: enable dropped mid-window.
        iRaw = 1'b0;
        level_latency(1'b0, n);
        steps(4);
        iRaw = 1'b1;
        steps(4);
        iEn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t6_no_tick", oTick, 0);
            check("t6_hold", oLevel, 0);
        end
        iEn = 1'b1;
        level_latency(1'b1, n);
        check("t6_resume", n, 3);

        // Randomized soak against the reference model.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                iRaw = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 99) < 3) ivPrescale = PB'($urandom_range(0, 5));
            if ($urandom_range(0, 99) < 3) ivFilterCnt = FB'($urandom_range(0, 4));
            if ($urandom_range(0, 99) < 4) iEn = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) < 3) begin
                iRst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                step();
                iRst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
